multiword_add_seq: RTL

- Sequencer stage that sits directly around a `full_adder` tile.
- Accepts one wide operand pair (WORDS x WIDTH bits) over a valid/ready handshake.
- Issues the pair to the adder one word per cycle, least-significant word first, and chains the adder's carry_out back into carry_in.
- Collects the word results into a wide sum and presents it downstream with a valid/ready handshake.
- The adder is combinational; this block supplies all sequencing and registering.

---
 rtl/multiword_add_seq_if.sv | 48 ++++
 rtl/multiword_add_seq.sv | 132 +++++++++++++
 2 files changed

// File: rtl/multiword_add_seq_if.sv
// Bundles the operand, result and adder-tile handshakes of multiword_add_seq.
// Macro MULTIWORD_ADD_SUB_EN adds the in_sub operand-mode bit.
interface multiword_add_seq_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned WORDS = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH*WORDS-1:0]   in_a;
  logic [WIDTH*WORDS-1:0]   in_b;
  logic                     in_cin;
`ifdef MULTIWORD_ADD_SUB_EN
  logic                     in_sub;
`endif
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH*WORDS-1:0]   out_sum;
  logic                     out_cout;
  logic                     out_err;
  logic [WIDTH-1:0]         add_a;
  logic [WIDTH-1:0]         add_b;
  logic                     add_carry_in;
  logic                     add_carry_listen;
  logic                     add_on_off;
  logic [WIDTH-1:0]         add_c;
  logic                     add_carry_out;
  logic                     add_ack;

  // Sequencer side.
  modport slave (
`ifdef MULTIWORD_ADD_SUB_EN
    input  in_sub,
`endif
    input  in_valid, in_a, in_b, in_cin, out_ready, add_c, add_carry_out, add_ack,
    output in_ready, out_valid, out_sum, out_cout, out_err,
    output add_a, add_b, add_carry_in, add_carry_listen, add_on_off
  );

  // Upstream, downstream and adder-tile side.
  modport master (
`ifdef MULTIWORD_ADD_SUB_EN
    output in_sub,
`endif
    output in_valid, in_a, in_b, in_cin, out_ready, add_c, add_carry_out, add_ack,
    input  in_ready, out_valid, out_sum, out_cout, out_err,
    input  add_a, add_b, add_carry_in, add_carry_listen, add_on_off
  );
endinterface

// File: rtl/multiword_add_seq.sv
// Word-serial wide adder sequencer around a combinational full_adder tile.
// Define MULTIWORD_ADD_SUB_EN to enable subtraction via in_sub.
module multiword_add_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  multiword_add_seq_if.slave bus
);
  localparam int unsigned W    = WIDTH * WORDS;
  localparam int unsigned CntW = $clog2(WORDS);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_nxt;
  logic              live_q, live_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [WIDTH-1:0]  add_a_q, add_a_d, add_b_q, add_b_d;
  logic              cin_q, cin_d, carry_q, carry_d, cout_q, cout_d;
  logic              err_q, err_d, rdy_q, rdy_d;

  assign cnt_nxt = cnt_q + CntW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    live_d  = live_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && rdy_q) begin
          a_d = bus.in_a;
          // Subtraction is folded into the latched operands: A + ~B + ~cin.
`ifdef MULTIWORD_ADD_SUB_EN
          b_d   = bus.in_sub ? ~bus.in_b : bus.in_b;
          cin_d = bus.in_sub ? ~bus.in_cin : bus.in_cin;
`else
          b_d   = bus.in_b;
          cin_d = bus.in_cin;
`endif
          err_d   = 1'b0;
          cnt_d   = '0;
          live_d  = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (!live_q) begin
          // First RUN cycle loads word 0 into the adder operand registers.
          live_d  = 1'b1;
          add_a_d = a_q[0 +: WIDTH];
          add_b_d = b_q[0 +: WIDTH];
        end else begin
          sum_d[int'(cnt_q)*WIDTH +: WIDTH] = bus.add_c;
          carry_d = bus.add_carry_out;
          if (!bus.add_ack) err_d = 1'b1;
          if (cnt_q == CntW'(WORDS - 1)) begin
            cout_d  = bus.add_carry_out;
            add_a_d = '0;
            add_b_d = '0;
            live_d  = 1'b0;
            state_d = StDone;
          end else begin
            cnt_d   = cnt_nxt;
            add_a_d = a_q[int'(cnt_nxt)*WIDTH +: WIDTH];
            add_b_d = b_q[int'(cnt_nxt)*WIDTH +: WIDTH];
          end
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Registered so in_ready stays low for the first cycle after reset release.
    rdy_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      live_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      live_q  <= live_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.in_ready         = rdy_q;
  assign bus.out_valid        = (state_q == StDone);
  assign bus.out_sum          = sum_q;
  assign bus.out_cout         = cout_q;
  assign bus.out_err          = err_q;
  assign bus.add_a            = add_a_q;
  assign bus.add_b            = add_b_q;
  assign bus.add_on_off       = (state_q == StRun);
  assign bus.add_carry_listen = (state_q == StRun);
  assign bus.add_carry_in     = (state_q == StRun && live_q) ?
                                ((cnt_q == '0) ? cin_q : carry_q) : 1'b0;
endmodule
